// File: rtl/ramen_pkg.sv
// ramen_pkg: shared encodings and recipe table for the ramen order engine
package ramen_pkg;
  typedef enum logic [1:0] {RAMEN_0, RAMEN_1, RAMEN_2, RAMEN_3} ramen_t;
  typedef enum logic [2:0] {ING_NOODLE, ING_BROTH, ING_TONKOTSU, ING_SOY, ING_MISO} ing_t;
  typedef enum logic [2:0] {IDLE, OPEN, GET_PORT, JUDGE, RESP, TOTAL} state_t;
  typedef logic [4:0][9:0] need_t;
  function automatic need_t mk(int n, int b, int t, int s, int m);
    return {10'(m), 10'(s), 10'(t), 10'(b), 10'(n)};
  endfunction
  localparam need_t RECIPES [8] = '{
    mk(100, 300, 150, 0, 0), mk(100, 300, 100, 30, 0), mk(100, 400, 0, 0, 30), mk(100, 300, 70, 15, 15),
    mk(150, 500, 200, 0, 0), mk(150, 500, 150, 50, 0), mk(150, 650, 0, 0, 50), mk(150, 500, 100, 25, 25)
  };
endpackage

// File: rtl/ramen_recipe_check.sv
// ramen_recipe_check: recipe lookup and inventory sufficiency test for one order
module ramen_recipe_check import ramen_pkg::*; #(
  parameter int ING_W = 16
) (
  input  logic [1:0]            ramen_type,
  input  logic                  portion,
  input  logic [4:0][ING_W-1:0] inv,
  output logic                  ok,
  output logic [4:0][ING_W-1:0] ded
);
  logic [4:0] enough;
  for (genvar i = 0; i < 5; i++) begin : g_ing
    assign ded[i] = ING_W'(RECIPES[{portion, ramen_type}][i]);
    assign enough[i] = inv[i] >= ded[i];
  end
  assign ok = &enough;
endmodule

// File: rtl/ramen_shop_multi.sv
// ramen_shop_multi: session-based two-beat ramen order engine with restocking and summary
module ramen_shop_multi import ramen_pkg::*; #(
  parameter int CNT_W = 7,
  parameter int ING_W = 16,
  parameter int GAIN_W = 17,
  parameter int PRICE_0 = 200,
  parameter int PRICE_1 = 250,
  parameter int PRICE_2 = 200,
  parameter int PRICE_3 = 250,
  parameter int INIT_NOODLE = 12000,
  parameter int INIT_BROTH = 41000,
  parameter int INIT_TONKOTSU = 9000,
  parameter int INIT_SOY = 1500,
  parameter int INIT_MISO = 1000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 selling,
  input  logic                 in_valid,
  input  logic [1:0]           ramen_type,
  input  logic                 portion,
  input  logic                 restock_valid,
  input  logic [2:0]           restock_id,
  input  logic [ING_W-1:0]     restock_amt,
  output logic                 restock_ack,
  output logic                 out_valid_order,
  output logic                 success,
  output logic                 out_valid_tot,
  output logic [4*CNT_W-1:0]   sold_num,
  output logic [CNT_W-1:0]     fail_num,
  output logic [GAIN_W-1:0]    total_gain
);
  localparam int PRICES [4] = '{PRICE_0, PRICE_1, PRICE_2, PRICE_3};
  state_t state, state_n;
  logic [1:0] typ;
  logic por, succ, ok, rs_ok;
  logic [4:0][ING_W-1:0] inv, ded;
  logic [3:0][CNT_W-1:0] cnt;
  logic [CNT_W-1:0] fails;
  logic [ING_W:0] rs_sum;
  logic [GAIN_W-1:0] gain;
  ramen_recipe_check #(.ING_W(ING_W)) u_check (
    .ramen_type(typ), .portion(por), .inv(inv), .ok(ok), .ded(ded)
  );
  always_comb begin
    state_n = IDLE;
    case (state)
      IDLE:     state_n = selling ? OPEN : IDLE;
      OPEN:     state_n = in_valid ? GET_PORT : !selling ? TOTAL : OPEN;
      GET_PORT: state_n = selling ? JUDGE : TOTAL;
      JUDGE:    state_n = selling ? RESP : TOTAL;
      RESP:     state_n = OPEN;
      default:  state_n = IDLE;
    endcase
  end
  always_comb begin
    gain = '0;
    for (int i = 0; i < 4; i++) gain += GAIN_W'(cnt[i]) * GAIN_W'(PRICES[i]);
  end
  assign rs_ok = state == OPEN && selling && restock_valid && !in_valid && restock_id <= ING_MISO;
  assign rs_sum = {1'b0, inv[restock_id]} + {1'b0, restock_amt};
  assign out_valid_order = state == RESP;
  assign success = out_valid_order && succ;
  assign out_valid_tot = state == TOTAL;
  assign sold_num = out_valid_tot ? {cnt[0], cnt[1], cnt[2], cnt[3]} : '0;
  assign fail_num = out_valid_tot ? fails : '0;
  assign total_gain = out_valid_tot ? gain : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      typ <= '0;
      por <= 1'b0;
      succ <= 1'b0;
      restock_ack <= 1'b0;
      inv <= '0;
      cnt <= '0;
      fails <= '0;
    end else begin
      state <= state_n;
      restock_ack <= rs_ok;
      if (state == IDLE && selling) begin
        inv <= {ING_W'(INIT_MISO), ING_W'(INIT_SOY), ING_W'(INIT_TONKOTSU), ING_W'(INIT_BROTH), ING_W'(INIT_NOODLE)};
        cnt <= '0;
        fails <= '0;
      end
      if (rs_ok) inv[restock_id] <= rs_sum[ING_W] ? '1 : rs_sum[ING_W-1:0];
      if (state == OPEN && in_valid) typ <= ramen_type;
      if (state == GET_PORT) por <= portion;
      if (state == JUDGE && selling) begin
        succ <= ok;
        if (ok) begin
          for (int i = 0; i < 5; i++) inv[i] <= inv[i] - ded[i];
          cnt[typ] <= cnt[typ] + CNT_W'(cnt[typ] != '1);
        end else fails <= fails + CNT_W'(fails != '1);
      end
    end
  end
endmodule

// File: tb/tb_ramen_shop_multi.sv
// tb_ramen_shop_multi: scoreboard bench running two widths of the ramen engine against a reference model
module tb_ramen_shop_multi;
  import ramen_pkg::*;
  logic clk = 0, rst = 1, selling = 0, in_valid = 0, portion = 0, restock_valid = 0;
  logic [1:0] ramen_type = 0;
  logic [2:0] restock_id = 0;
  logic [15:0] restock_amt = 0;
  logic ack_a, ovo_a, s_a, tv_a, ack_b, ovo_b, s_b, tv_b;
  logic [27:0] sold_a;
  logic [11:0] sold_b;
  logic [6:0] fail_a;
  logic [2:0] fail_b;
  logic [16:0] gain_a, gain_b;
  always #5 clk = ~clk;
  ramen_shop_multi dut_a (
    .clk(clk), .rst(rst), .selling(selling), .in_valid(in_valid), .ramen_type(ramen_type),
    .portion(portion), .restock_valid(restock_valid), .restock_id(restock_id), .restock_amt(restock_amt),
    .restock_ack(ack_a), .out_valid_order(ovo_a), .success(s_a), .out_valid_tot(tv_a),
    .sold_num(sold_a), .fail_num(fail_a), .total_gain(gain_a)
  );
  ramen_shop_multi #(.CNT_W(3)) dut_b (
    .clk(clk), .rst(rst), .selling(selling), .in_valid(in_valid), .ramen_type(ramen_type),
    .portion(portion), .restock_valid(restock_valid), .restock_id(restock_id), .restock_amt(restock_amt),
    .restock_ack(ack_b), .out_valid_order(ovo_b), .success(s_b), .out_valid_tot(tv_b),
    .sold_num(sold_b), .fail_num(fail_b), .total_gain(gain_b)
  );
  typedef struct {int c; int v;} ev_t;
  typedef struct {int c; int s; int f; int g;} tot_t;
  localparam int NEED [8][5] = '{
    '{100, 300, 150, 0, 0}, '{100, 300, 100, 30, 0}, '{100, 400, 0, 0, 30}, '{100, 300, 70, 15, 15},
    '{150, 500, 200, 0, 0}, '{150, 500, 150, 50, 0}, '{150, 650, 0, 0, 50}, '{150, 500, 100, 25, 25}
  };
  localparam int INIT [5] = '{12000, 41000, 9000, 1500, 1000};
  localparam int PRICE [4] = '{200, 250, 200, 250};
  localparam int WIDTHS [2] = '{7, 3};
  ev_t qo [2][$];
  ev_t qa [2][$];
  tot_t qt [2][$];
  int checks = 0, errors = 0, cyc = 0;
  bit mon_en = 0;
  int inv [5];
  int raw [4];
  int rawf;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", n, cyc, act, exp);
    end
  endtask
  function automatic int sat(input int v, input int w);
    return v > (1 << w) - 1 ? (1 << w) - 1 : v;
  endfunction
  task automatic push_tot(input int c);
    for (int k = 0; k < 2; k++) begin
      tot_t t;
      int s;
      t.c = c;
      t.s = 0;
      t.g = 0;
      for (int i = 0; i < 4; i++) begin
        s = sat(raw[i], WIDTHS[k]);
        t.s = (t.s << WIDTHS[k]) | s;
        t.g += s * PRICE[i];
      end
      t.f = sat(rawf, WIDTHS[k]);
      qt[k].push_back(t);
    end
  endtask
  task automatic mon(input int k, input logic ovo, input logic s, input logic ack, input logic tv,
                     input int sold, input int f, input int g);
    ev_t e;
    tot_t t;
    if (qo[k].size() > 0 && qo[k][0].c == cyc) begin
      e = qo[k].pop_front();
      check($sformatf("dut%0d order_valid", k), int'(ovo), 1);
      check($sformatf("dut%0d success", k), int'(s), e.v);
    end else begin
      check($sformatf("dut%0d order_valid_quiet", k), int'(ovo), 0);
      check($sformatf("dut%0d success_quiet", k), int'(s), 0);
    end
    if (qa[k].size() > 0 && qa[k][0].c == cyc) begin
      e = qa[k].pop_front();
      check($sformatf("dut%0d restock_ack", k), int'(ack), e.v);
    end else check($sformatf("dut%0d restock_ack_quiet", k), int'(ack), 0);
    if (qt[k].size() > 0 && qt[k][0].c == cyc) begin
      t = qt[k].pop_front();
      check($sformatf("dut%0d tot_valid", k), int'(tv), 1);
      check($sformatf("dut%0d sold_num", k), sold, t.s);
      check($sformatf("dut%0d fail_num", k), f, t.f);
      check($sformatf("dut%0d total_gain", k), g, t.g);
    end else begin
      check($sformatf("dut%0d tot_valid_quiet", k), int'(tv), 0);
      check($sformatf("dut%0d summary_quiet", k), sold | f | g, 0);
    end
  endtask
  always @(negedge clk) begin
    if (mon_en) begin
      mon(0, ovo_a, s_a, ack_a, tv_a, int'(sold_a), int'(fail_a), int'(gain_a));
      mon(1, ovo_b, s_b, ack_b, tv_b, int'(sold_b), int'(fail_b), int'(gain_b));
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic reload();
    for (int i = 0; i < 5; i++) inv[i] = INIT[i];
    for (int i = 0; i < 4; i++) raw[i] = 0;
    rawf = 0;
  endtask
  task automatic open_s();
    selling = 1;
    reload();
    step();
  endtask
  task automatic rs(input bit en);
    restock_valid = en;
    restock_id = 3'($urandom_range(0, 4));
    restock_amt = 16'($urandom_range(1, 5000));
  endtask
  task automatic close_s(input bit with_rs);
    selling = 0;
    rs(with_rs);
    push_tot(cyc + 1);
    step();
    rs(0);
    step();
  endtask
  task automatic restock(input int id, input int amt);
    restock_valid = 1;
    restock_id = 3'(id);
    restock_amt = 16'(amt);
    if (id <= 4) begin
      inv[id] = inv[id] + amt > 65535 ? 65535 : inv[id] + amt;
      for (int k = 0; k < 2; k++) qa[k].push_back(ev_t'{cyc + 1, 1});
    end
    step();
    restock_valid = 0;
  endtask
  task automatic order(input int t, input int p, input int rsw, input int ab);
    int a;
    int idx;
    bit ok;
    a = cyc;
    idx = p * 4 + t;
    ok = 1;
    for (int i = 0; i < 5; i++) if (inv[i] < NEED[idx][i]) ok = 0;
    if (ab != 0) push_tot(a + 1 + ab);
    else begin
      for (int k = 0; k < 2; k++) qo[k].push_back(ev_t'{a + 3, int'(ok)});
      if (ok) begin
        for (int i = 0; i < 5; i++) inv[i] -= NEED[idx][i];
        raw[t]++;
      end else rawf++;
    end
    in_valid = 1;
    ramen_type = 2'(t);
    portion = 1'($urandom);
    rs(rsw == 1);
    step();
    portion = 1'(p);
    ramen_type = 2'($urandom);
    rs(rsw == 2);
    if (ab == 1) selling = 0;
    step();
    in_valid = 0;
    rs(rsw == 3);
    if (ab == 2) selling = 0;
    step();
    rs(rsw == 4);
    step();
    rs(0);
  endtask
  task automatic reset_mid();
    in_valid = 1;
    ramen_type = 2'($urandom);
    step();
    portion = 1'($urandom);
    rst = 1;
    step();
    rst = 0;
    in_valid = 0;
    check("reset_state_a", int'(dut_a.state), int'(IDLE));
    check("reset_state_b", int'(dut_b.state), int'(IDLE));
    check("reset_outputs_a", int'({ack_a, ovo_a, s_a, tv_a}) | int'(sold_a) | int'(fail_a) | int'(gain_a), 0);
    check("reset_outputs_b", int'({ack_b, ovo_b, s_b, tv_b}) | int'(sold_b) | int'(fail_b) | int'(gain_b), 0);
    reload();
    step();
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end
  initial begin
    repeat (3) step();
    rst = 0;
    mon_en = 1;
    open_s();
    order(0, 1, 0, 0);
    close_s(0);
    open_s();
    repeat (34) order(2, 0, 0, 0);
    restock(4, 500);
    order(2, 0, 0, 0);
    close_s(0);
    open_s();
    restock(6, 100);
    order(3, 1, 1, 0);
    order(1, 0, 2, 0);
    order(0, 0, 4, 0);
    close_s(1);
    open_s();
    repeat (9) order(1, 0, 0, 0);
    close_s(0);
    open_s();
    order(0, 0, 0, 0);
    order(2, 1, 0, 2);
    open_s();
    order(1, 1, 0, 1);
    open_s();
    reset_mid();
    order(0, 0, 0, 0);
    close_s(0);
    open_s();
    restock(0, 60000);
    restock(2, 60000);
    repeat (130) order(0, 0, 0, 0);
    close_s(0);
    for (int n = 0; n < 15; n++) begin
      bit done;
      int r;
      done = 0;
      open_s();
      for (int j = 0; j < 30 && !done; j++) begin
        r = $urandom_range(0, 11);
        if (r < 6) order($urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 2) == 0 ? $urandom_range(1, 4) : 0, 0);
        else if (r < 8) restock($urandom_range(0, 7), $urandom_range(0, 3) == 0 ? $urandom_range(0, 65535) : $urandom_range(0, 2000));
        else if (r == 10) begin
          order($urandom_range(0, 3), $urandom_range(0, 1), 0, $urandom_range(1, 2));
          done = 1;
        end else step();
      end
      if (!done) close_s(1'($urandom));
    end
    repeat (5) step();
    for (int k = 0; k < 2; k++) check($sformatf("dut%0d pending_events", k), qo[k].size() + qa[k].size() + qt[k].size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ramen_shop_multi.md
Name: ramen_shop_multi

Overview:
- Parametrised successor to the single-window ramen order engine.
- Takes two-beat orders (type, then portion) during a selling session, checks five ingredient inventories against a fixed recipe table, and deducts on success.
- New over the previous generation: mid-session restocking, per-type prices and initial stock as parameters, saturating counters and a rejected-order count.
- Emits an end-of-session summary; sits between the order front-end and the daily accounting logic.

Parameters:
- CNT_W, 7: width of each per-type sold counter and of the fail counter.
- ING_W, 16: width of each inventory register; also the restock cap, 2^ING_W-1.
- GAIN_W, 17: total_gain width.
- PRICE_0..PRICE_3, 200/250/200/250: price per bowl for types 0-3, independent of portion.
- INIT_NOODLE/BROTH/TONKOTSU/SOY/MISO, 12000/41000/9000/1500/1000: stock loaded at session open.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- selling  in  1  session window, high for the whole session.
- in_valid  in  1  order beat strobe, exactly two consecutive cycles per order.
- ramen_type  in  2  sampled on beat 0.
- portion  in  1  sampled on beat 1; 0 = small, 1 = big.
- restock_valid  in  1  one-cycle restock request.
- restock_id  in  3  0 noodle, 1 broth, 2 tonkotsu, 3 soy, 4 miso; 5-7 invalid.
- restock_amt  in  ING_W  amount to add.
- restock_ack  out  1  one-cycle pulse, cycle after an accepted restock.
- out_valid_order  out  1  one-cycle order response.
- success  out  1  valid with out_valid_order; 0 otherwise.
- out_valid_tot  out  1  one-cycle summary strobe.
- sold_num  out  4*CNT_W  per-type counts, type0 in the MSB field; 0 when out_valid_tot is low.
- fail_num  out  CNT_W  rejected orders; 0 when out_valid_tot is low.
- total_gain  out  GAIN_W  sum of count_i*PRICE_i; 0 when out_valid_tot is low.

Behaviour:
- Reset: FSM to IDLE; all outputs and counters 0; inventory 0. Reset overrides every other input in the same cycle. Reset mid-order drops the order with no response.
- States: IDLE, OPEN, GET_PORT, JUDGE, RESP, TOTAL.
- IDLE: selling=1 loads INIT_* into inventory, clears counters, goes to OPEN.
- OPEN:
  - in_valid -> latch type, go to GET_PORT.
  - else selling=0 -> TOTAL.
  - else stay.
- GET_PORT: latch portion, go to JUDGE.
- JUDGE: recipe check.
  - On success: deduct inventory and increment the type counter (saturate at 2^CNT_W-1).
  - On failure: increment fail_num (saturating).
  - Register success either way; go to RESP.
- RESP: out_valid_order=1; next state OPEN.
- Latency: response in cycle T+2, where T is the portion beat. Back-to-back orders are legal from the cycle after RESP.
- TOTAL: out_valid_tot=1 with outputs from the final counters; next state IDLE.
- Recipes (noodle, broth, tonkotsu, soy, miso), small / big:
  - type0: 100,300,150,0,0 / 150,500,200,0,0
  - type1: 100,300,100,30,0 / 150,500,150,50,0
  - type2: 100,400,0,0,30 / 150,650,0,0,50
  - type3: 100,300,70,15,15 / 150,500,100,25,25
- Sufficiency: every ingredient must be >= its requirement (equality passes). No partial deduction.
- Restock:
  - Accepted only in OPEN, with in_valid=0, restock_id<=4 and selling=1.
  - Effect: inventory += amt, saturating at 2^ING_W-1.
  - restock_ack pulses the next cycle.
  - Rejected requests are dropped with no ack. This includes restock in any other state, a restock simultaneous with order beat 0, and invalid ids.
- selling falling while an order is in flight (GET_PORT or JUDGE): order aborted, no response, no deduction; go to TOTAL.
- Gain: computed at full GAIN_W width from the saturated counts; no wrap at default parameters (4*127*250 = 127000 < 2^17).

Decomposition:
- ramen_pkg:
  - ramen type encoding
  - ingredient id encoding
  - recipe requirement constants, small/big per type
  - state encoding
- One sub-module, ramen_recipe_check: combinational. Inputs: type, portion, five inventories. Outputs: ok flag and five deduction values. Instanced once by the FSM.

Test Plan:
1. Open session; order type0 big -> success=1 at T+2; noodle 11850, broth 40500, tonkotsu 8800. Drop selling -> sold_num field0=1, total_gain=200, fail_num=0.
2. 34 type2 small orders -> first 33 succeed, 34th success=0 (miso 10 < 30). Summary: field2=33, fail_num=1, gain=6600.
3. After scenario 2's failure, restock id4 amt 500 -> restock_ack next cycle; next type2 small succeeds; miso 480.
4. Restock with id 6, and a restock simultaneous with in_valid beat 0 -> no ack, inventory unchanged; the order is processed normally.
5. CNT_W=3; 9 successful type1 small orders -> field1 saturates at 7, gain=1750.
6. selling drops in the JUDGE cycle -> no out_valid_order; out_valid_tot next cycle with the pre-order counts. Assert rst during GET_PORT -> all outputs 0 next cycle, FSM in IDLE.
